// File: rtl/seg_pattern_decoder.sv
// Debounces an active-low 7-segment pattern for STABLE_CYCLES samples, then decodes it to a hex digit.
// Holds the result until out_ready; strobes arriving while a result is pending are counted as overruns.
module seg_pattern_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       seg_strobe,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_invalid,
  output logic       out_blank,
  output logic [7:0] err_count,
  output logic [7:0] overrun_count
);

  localparam logic [3:0] N_STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, FILTER, EMIT} state_t;

  typedef struct packed {
    logic       invalid;
    logic       blank;
    logic [3:0] digit;
  } dec_t;

  state_t     state_q;
  logic [6:0] cand_q;
  logic [3:0] cnt_q;
  logic       valid_q;
  logic [3:0] digit_q;
  logic       invalid_q;
  logic       blank_q;
  logic [7:0] err_q;
  logic [7:0] ovr_q;

  logic [3:0] cnt_d;
  dec_t       dec_d;

  function automatic dec_t decode(input logic [6:0] seg);
    dec_t r;
    r = '{invalid: 1'b0, blank: 1'b0, digit: 4'h0};
    case (seg)
      7'b1000000: r.digit = 4'h0;
      7'b1111001: r.digit = 4'h1;
      7'b0100100: r.digit = 4'h2;
      7'b0110000: r.digit = 4'h3;
      7'b0011001: r.digit = 4'h4;
      7'b0010010: r.digit = 4'h5;
      7'b0000010: r.digit = 4'h6;
      7'b1111000: r.digit = 4'h7;
      7'b0000000: r.digit = 4'h8;
      7'b0010000: r.digit = 4'h9;
      7'b0001000: r.digit = 4'hA;
      7'b0000011: r.digit = 4'hB;
      7'b1000110: r.digit = 4'hC;
      7'b0100001: r.digit = 4'hD;
      7'b0000110: r.digit = 4'hE;
      7'b0001110: r.digit = 4'hF;
      7'b1111111: r.blank = 1'b1;
      default:    r.invalid = 1'b1;
    endcase
    return r;
  endfunction

  // Whenever a result is loaded, seg_in equals the candidate, so seg_in is decoded directly.
  always_comb begin
    cnt_d = (seg_in == cand_q) ? cnt_q + 4'd1 : 4'd1;
    dec_d = decode(seg_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= 7'd0;
      cnt_q     <= 4'd0;
      valid_q   <= 1'b0;
      digit_q   <= 4'd0;
      invalid_q <= 1'b0;
      blank_q   <= 1'b0;
      err_q     <= 8'd0;
      ovr_q     <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seg_strobe) begin
            cand_q <= seg_in;
            cnt_q  <= 4'd1;
            if (N_STABLE == 4'd1) begin
              state_q   <= EMIT;
              valid_q   <= 1'b1;
              digit_q   <= dec_d.digit;
              invalid_q <= dec_d.invalid;
              blank_q   <= dec_d.blank;
              if (dec_d.invalid && err_q != 8'hFF) err_q <= err_q + 8'd1;
            end else begin
              state_q <= FILTER;
            end
          end
        end
        FILTER: begin
          cand_q <= seg_in;
          cnt_q  <= cnt_d;
          if (cnt_d == N_STABLE) begin
            state_q   <= EMIT;
            valid_q   <= 1'b1;
            digit_q   <= dec_d.digit;
            invalid_q <= dec_d.invalid;
            blank_q   <= dec_d.blank;
            if (dec_d.invalid && err_q != 8'hFF) err_q <= err_q + 8'd1;
          end
        end
        EMIT: begin
          if (seg_strobe && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid     = valid_q;
  assign out_digit     = digit_q;
  assign out_invalid   = invalid_q;
  assign out_blank     = blank_q;
  assign err_count     = err_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder with STABLE_CYCLES=4: latency, filtering, flags, counters, reset.
module tb_seg_pattern_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       seg_strobe;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_invalid;
  logic       out_blank;
  logic [7:0] err_count;
  logic [7:0] overrun_count;

  int n_tests = 0;
  int n_fail  = 0;

  seg_pattern_decoder #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_in       (seg_in),
    .seg_strobe   (seg_strobe),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_digit    (out_digit),
    .out_invalid  (out_invalid),
    .out_blank    (out_blank),
    .err_count    (err_count),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_pattern(input logic [6:0] seg, output logic [3:0] d,
                             output logic inv, output logic blk);
    seg_in     = seg;
    seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    wait_valid();
    d   = out_digit;
    inv = out_invalid;
    blk = out_blank;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [6:0] glyph [16];
  logic [3:0] d;
  logic       inv, blk;
  logic       seen;

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    reset = 1'b1; seg_in = 7'h7F; seg_strobe = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_digit", {28'd0, out_digit}, 32'd0);
    check("rst_flags", {30'd0, out_invalid, out_blank}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    check("rst_ovr", {24'd0, overrun_count}, 32'd0);
    reset = 1'b0;

    // Latency: strobe in cycle 0, valid in cycle 4 only
    seg_in = 7'b0100100; seg_strobe = 1'b1; out_ready = 1'b1;
    tick();
    seg_strobe = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check($sformatf("lat_low_c%0d", c), {31'd0, out_valid}, 32'd0);
      tick();
    end
    check("lat_valid_c4", {31'd0, out_valid}, 32'd1);
    check("lat_digit", {28'd0, out_digit}, 32'd2);
    check("lat_flags", {30'd0, out_invalid, out_blank}, 32'd0);
    tick();
    check("lat_valid_c5", {31'd0, out_valid}, 32'd0);

    // Candidate reload: change in cycle 2 pushes valid to cycle 6
    seg_in = 7'b0110000; seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    tick();
    seg_in = 7'b0011001;
    tick(); tick(); tick();
    check("reload_low_c5", {31'd0, out_valid}, 32'd0);
    tick();
    check("reload_valid_c6", {31'd0, out_valid}, 32'd1);
    check("reload_digit", {28'd0, out_digit}, 32'd4);
    tick();
    out_ready = 1'b0;

    // Invalid glyph and err_count saturation
    run_pattern(7'b0101010, d, inv, blk);
    check("inv_flag", {31'd0, inv}, 32'd1);
    check("inv_digit", {28'd0, d}, 32'd0);
    check("inv_blank", {31'd0, blk}, 32'd0);
    check("inv_err1", {24'd0, err_count}, 32'd1);
    for (int i = 1; i < 300; i++) run_pattern(7'b0101010, d, inv, blk);
    check("err_sat", {24'd0, err_count}, 32'd255);

    // Backpressure with strobes in EMIT
    seg_in = 7'b1111001; seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("hold_digit_%0d", i), {28'd0, out_digit}, 32'd1);
      seg_strobe = (i == 1 || i == 4 || i == 7);
      tick();
      seg_strobe = 1'b0;
    end
    check("ovr_3", {24'd0, overrun_count}, 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("accept_drop", {31'd0, out_valid}, 32'd0);

    // Strobe in the accepting cycle is dropped and counted
    seg_in = 7'b0100100; seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    wait_valid();
    out_ready = 1'b1; seg_strobe = 1'b1;
    tick();
    out_ready = 1'b0; seg_strobe = 1'b0;
    check("ovr_accept", {24'd0, overrun_count}, 32'd4);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= out_valid;
      tick();
    end
    check("accept_strobe_ignored", {31'd0, seen}, 32'd0);

    // Reset during FILTER
    seg_in = 7'b0100100; seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstf_valid", {31'd0, out_valid}, 32'd0);
    check("rstf_err", {24'd0, err_count}, 32'd0);
    check("rstf_ovr", {24'd0, overrun_count}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= out_valid;
    end
    check("rstf_discarded", {31'd0, seen}, 32'd0);

    // Reset during EMIT
    seg_in = 7'b0110000; seg_strobe = 1'b1;
    tick();
    seg_strobe = 1'b0;
    wait_valid();
    check("rste_pre_digit", {28'd0, out_digit}, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rste_valid", {31'd0, out_valid}, 32'd0);
    check("rste_digit", {28'd0, out_digit}, 32'd0);

    run_pattern(7'b1111111, d, inv, blk);
    check("blank_flag", {31'd0, blk}, 32'd1);
    check("blank_inv", {31'd0, inv}, 32'd0);
    check("blank_digit", {28'd0, d}, 32'd0);
    check("blank_err", {24'd0, err_count}, 32'd0);

    // Full glyph table in order
    for (int i = 0; i < 16; i++) begin
      run_pattern(glyph[i], d, inv, blk);
      check($sformatf("glyph_%0d_digit", i), {28'd0, d}, i);
      check($sformatf("glyph_%0d_flags", i), {30'd0, inv, blk}, 32'd0);
    end
    check("glyph_err", {24'd0, err_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_pattern_decoder.md
SEG_PATTERN_DECODER -- requirements
Module: seg_pattern_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal range 1..15: consecutive identical samples needed before a pattern is accepted.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  7  active-low segment pattern; bit0=a, bit1=b ... bit6=g (clockwise a-f, g middle).
REQ-005 seg_strobe  input  1  one-cycle request to start sampling seg_in.
REQ-006 out_ready  input  1  consumer accepts the result in any cycle where out_valid=1.
REQ-007 out_valid  output  1  decoded result held stable until accepted.
REQ-008 out_digit  output  4  decoded hex value 0x0..0xF.
REQ-009 out_invalid  output  1  accepted pattern matched no hex glyph and was not blank.
REQ-010 out_blank  output  1  accepted pattern was 7'b1111111 (all segments off).
REQ-011 err_count  output  8  saturating count of invalid patterns.
REQ-012 overrun_count  output  8  saturating count of dropped strobes.

Function
REQ-013 Decode table (seg_in -> digit) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->b, 1000110->C, 0100001->d, 0000110->E, 0001110->F (bit6..bit0).
REQ-014 FSM states SHALL be IDLE, FILTER, EMIT.
REQ-015 IDLE: on seg_strobe=1, capture seg_in into candidate register and set stability count to 1; go to FILTER, or directly to EMIT if STABLE_CYCLES=1.
REQ-016 FILTER: seg_in equal to candidate increments the count; seg_in different reloads the candidate with seg_in and sets the count to 1.
REQ-017 FILTER: when the count reaches STABLE_CYCLES, the FSM SHALL decode the candidate, load outputs, and enter EMIT.
REQ-018 Latency: strobe sampled in cycle T with seg_in unchanged for cycles T..T+N-1 -> out_valid first high in cycle T+N (N=STABLE_CYCLES).
REQ-019 seg_strobe in FILTER SHALL be ignored (not counted); sampling continues.
REQ-020 EMIT: out_valid=1; out_digit, out_invalid and out_blank SHALL remain constant until a cycle with out_ready=1.
REQ-021 EMIT with out_ready=1: out_valid=0 from the next cycle; FSM returns to IDLE.
REQ-022 seg_strobe in EMIT, including the accepting cycle, SHALL be dropped and SHALL increment overrun_count.
REQ-023 Unmatched non-blank pattern: out_digit=0, out_invalid=1, out_blank=0; err_count increments once, on entry to EMIT.
REQ-024 Blank pattern: out_digit=0, out_blank=1, out_invalid=0; no err_count change.
REQ-025 Matched pattern: out_invalid=0, out_blank=0.
REQ-026 err_count and overrun_count SHALL saturate at 255 and never wrap.
REQ-027 out_digit, out_invalid and out_blank SHALL be registered; no combinational path from seg_in to any output.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, out_valid=0, out_digit=0, out_invalid=0, out_blank=0, err_count=0, overrun_count=0, candidate=0, count=0.
REQ-029 Reset SHALL take priority over all other inputs in any state; an in-flight result is discarded with no handshake.
REQ-030 After reset deasserts, the first strobe SHALL be processed normally.

Verification
REQ-031 N=4; seg_in=0100100, strobe in cycle 0, out_ready=1 -> out_valid high in cycle 4 only, out_digit=2, flags 0.
REQ-032 N=4; strobe with 0110000, seg_in changes to 0011001 in cycle 2 and is then held -> out_valid in cycle 6, out_digit=4.
REQ-033 Pattern 0101010 -> out_invalid=1, out_digit=0, err_count=1; repeat 300 times -> err_count=255.
REQ-034 out_ready=0 for 10 cycles in EMIT with 3 strobes -> outputs stable, overrun_count=3; then out_ready=1 -> out_valid=0 next cycle.
REQ-035 reset pulsed in FILTER and in EMIT -> all outputs 0 next cycle; subsequent strobe with 1111111 -> out_blank=1, err_count=0.
REQ-036 All 16 glyphs from REQ-013 sent in sequence -> out_digit 0x0..0xF in order, flags 0.
